// File: rtl/edge_det_multi.sv
// edge_det_multi: per-channel synchroniser + debounce filter with one-cycle
// rising/falling edge strobes, mode-qualified events, sticky event flags
// and a shared saturating event counter.
module edge_det_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     sig,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     clr,
    input  logic                cnt_clr,
    output logic [N_CH-1:0]     pe,
    output logic [N_CH-1:0]     ne,
    output logic [N_CH-1:0]     ev,
    output logic [N_CH-1:0]     sticky,
    output logic [CNT_W-1:0]    ev_cnt
);

    // Debounce counter counts 0..DEB_CYCLES-1; at least one bit wide.
    localparam int             DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);
    // Sum width wide enough to hold a saturated count plus one batch of events.
    localparam int             SUM_W    = CNT_W + $clog2(N_CH + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [DW-1:0]          deb_q    [N_CH];
    logic [DW-1:0]          deb_next [N_CH];
    logic [N_CH-1:0]        syn;
    logic [N_CH-1:0]        flt;
    logic [N_CH-1:0]        flt_next;
    logic [N_CH-1:0]        pe_next;
    logic [N_CH-1:0]        ne_next;
    logic [N_CH-1:0]        ev_next;
    logic [SUM_W-1:0]       cnt_sum;
    logic [CNT_W-1:0]       cnt_next;

    // Synchroniser chains: raw input enters at bit 0, syn taken from the top flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig[i]};
        end
    end

    // Debounce decision: a differing level must persist DEB_CYCLES samples;
    // any sample matching the filtered level restarts the count.
    always_comb begin
        flt_next = flt;
        pe_next  = '0;
        ne_next  = '0;
        ev_next  = '0;
        syn      = '0;
        for (int i = 0; i < N_CH; i++) begin
            deb_next[i] = deb_q[i];
            syn[i]      = sync_q[i][SYNC_STAGES-1];
            if (syn[i] == flt[i]) begin
                deb_next[i] = '0;
            end else if (deb_q[i] == DEB_LAST) begin
                deb_next[i] = '0;
                flt_next[i] = syn[i];
                pe_next[i]  = syn[i];
                ne_next[i]  = ~syn[i];
            end else begin
                deb_next[i] = deb_q[i] + DW'(1);
            end
            // Mode only qualifies the event, never the edge itself.
            ev_next[i] = (pe_next[i] & mode[2*i]) | (ne_next[i] & mode[2*i+1]);
        end
    end

    // Filtered level, debounce counters and the registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt <= '0;
            pe  <= '0;
            ne  <= '0;
            ev  <= '0;
            for (int i = 0; i < N_CH; i++) deb_q[i] <= '0;
        end else begin
            flt <= flt_next;
            pe  <= pe_next;
            ne  <= ne_next;
            ev  <= ev_next;
            for (int i = 0; i < N_CH; i++) deb_q[i] <= deb_next[i];
        end
    end

    // Sticky flags: an event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky <= '0;
        else        sticky <= (sticky & ~clr) | ev;
    end

    // Next counter value: add this cycle's events, clamp at all-ones,
    // cnt_clr wins and drops the events of that cycle.
    always_comb begin
        cnt_sum  = SUM_W'(ev_cnt) + SUM_W'($countones(ev));
        cnt_next = ev_cnt;
        if (cnt_clr)                cnt_next = '0;
        else if (cnt_sum > CNT_MAX) cnt_next = {CNT_W{1'b1}};
        else                        cnt_next = cnt_sum[CNT_W-1:0];
    end

    // Shared event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ev_cnt <= '0;
        else        ev_cnt <= cnt_next;
    end

endmodule
